johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 4-bit Johnson counter. Samples the counter's 8-state code, validates it, and tracks lock to the legal shift sequence. While locked it outputs the phase as a binary index and as a one-hot vector, pulses on every full revolution, and counts revolutions. Illegal codes and sequence skips are flagged so the phase-sequenced datapath downstream can ignore unlocked phases.

## Interface
Parameters:
- `REV_W`, default 8: width of the revolution counter.
- `LOCK_CNT`, default 2: consecutive correct successor steps required to enter LOCKED. Legal range 1..7.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `valid`, in, 1: sample strobe; tie to the counter's `enable`. `jc_in` is evaluated only when `valid` = 1.
- `jc_in`, in, 4: Johnson code from the counter.
- `clr_err`, in, 1: clears `err_sticky`.
- `phase`, out, 3: decoded phase index.
- `phase_onehot`, out, 8: `1 << phase` while locked, otherwise 0.
- `phase_valid`, out, 1: 1 while in the LOCKED state.
- `wrap`, out, 1: one-cycle pulse on a locked 7→0 step.
- `rev_count`, out, REV_W: number of locked revolutions.
- `illegal`, out, 1: one-cycle pulse when an illegal code is sampled.
- `skip`, out, 1: one-cycle pulse when a legal but out-of-sequence code is sampled in LOCKED.
- `err_sticky`, out, 1: latched error flag.

## Operation
- **Decode:** 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7. The other 8 codes are illegal.
- **Successor:** succ(p) = (p+1) mod 8. A sample equal to `prev` is a hold; a hold is never an error.
- **Internal state:** `prev` (3 bits) and `run` (3 bits).
- **States:** UNLOCKED, ACQUIRE, LOCKED.
  - **UNLOCKED:** a legal sample loads `prev`, clears `run`, and moves to ACQUIRE.
  - **ACQUIRE:** succ sample sets `prev`=sample and increments `run`. When `run`+1 = LOCK_CNT, move to LOCKED. A hold changes nothing. Any other legal sample sets `prev`=sample and `run`=0.
  - **LOCKED:** succ or hold updates `prev`. Any other legal sample pulses `skip`, sets `prev`=sample and `run`=0, and moves to ACQUIRE.
  - **Any state:** an illegal sample pulses `illegal` and moves to UNLOCKED. `prev` and `run` are held.
- **Phase outputs:** `phase` follows `prev` while in LOCKED or on entry to LOCKED. Outside LOCKED, `phase` holds its last value and `phase_onehot`=0.
- **Revolutions:** a 7→0 step taken in LOCKED pulses `wrap` and increments `rev_count`, modulo 2^REV_W with silent wrap. The step that enters LOCKED never pulses `wrap`.
- **Sticky error:** `illegal` or `skip` sets `err_sticky`. `clr_err` clears it. When set and clear coincide, set wins.
- **`valid`=0:** all state and counters hold; `wrap`, `illegal`, and `skip` are 0.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in every output after edge N, so latency is 1 cycle.
- **Reset value of every output:** `phase`=0, `phase_onehot`=0, `phase_valid`=0, `wrap`=0, `rev_count`=0, `illegal`=0, `skip`=0, `err_sticky`=0. Internally the FSM resets to UNLOCKED with `prev`=0 and `run`=0.
- `reset_n` overrides `valid` and `clr_err` on the same edge. Reset asserted mid-revolution discards lock; re-lock needs LOCK_CNT further succ steps.
- With LOCK_CNT=2, a clean stream starting at 0000 is locked after edge 3: the 0000, 1000, and 1100 samples.
- **Pulse widths:** `wrap`, `illegal`, and `skip` are exactly one cycle per qualifying sample. Back-to-back qualifying samples produce back-to-back pulses.

## Configuration
- **`JPD_ERR_COUNT_EN` defined:** adds output `err_count` (8 bits, reset 0). It increments on each `illegal` or `skip` pulse and saturates at 255. `clr_err` zeroes it, except that on a coinciding error it loads 1.
- **Not defined:** the port and its logic are absent; all other behaviour is identical.

## Test plan
- **Clean lock:** reset, then `valid`=1 with the legal sequence from 0000 for 20 cycles → `phase_valid` rises after the third sample; `phase` steps 2,3,…,7,0…. `wrap` pulses at each 0001→0000, giving `rev_count`=2 at the end; no errors.
- **Hold:** while locked, hold `jc_in`=1110 with `valid`=1 for 5 cycles → `phase`=3 and `phase_onehot`=0x08 stay steady, with no `skip`. Dropping `valid` freezes all outputs.
- **Illegal code:** inject 1010 while locked → `illegal` pulses one cycle, `phase_valid`=0, `phase_onehot`=0, `err_sticky`=1. Resuming the legal sequence re-locks after LOCK_CNT steps.
- **Skip:** step locked phase 2 → 5 (1100 then 0111) → `skip` pulses and state returns to ACQUIRE. Then 0011 and 0001 → relocked with `phase`=7.
- **Error clear race:** assert `clr_err` in the same cycle as an illegal sample → `err_sticky` stays 1. Then `clr_err` alone → 0. With the macro defined, `err_count` reads 1 after the race cycle and 0 after the clear.
- **Revolution wrap and reset:** with REV_W=2, run 5 locked revolutions → `rev_count` reads 1. Assert `reset_n`=0 for one cycle mid-revolution → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// Johnson-code phase decoder: validates 4-bit Johnson samples, tracks lock to the shift
// sequence and reports phase, revolutions and errors. Optional macro JPD_ERR_COUNT_EN adds err_count.
module johnson_phase_decoder #(
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [3:0]       jc_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic [7:0]       phase_onehot,
  output logic             phase_valid,
  output logic             wrap,
  output logic [REV_W-1:0] rev_count,
  output logic             illegal,
  output logic             skip,
  output logic             err_sticky
`ifdef JPD_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  // Handshake: valid qualifies jc_in for exactly the cycle it is high; there is no
  // backpressure, and valid=0 freezes all state while forcing the pulse outputs low.

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [2:0]       LOCK_RUN = 3'(LOCK_CNT);
  localparam logic [REV_W-1:0] REV_ONE  = {{(REV_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       run_q, run_d;
  logic [2:0]       phase_q, phase_d;
  logic [7:0]       onehot_q, onehot_d;
  logic             phase_valid_q, phase_valid_d;
  logic             wrap_q, wrap_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             illegal_q, illegal_d;
  logic             skip_q, skip_d;
  logic             err_q, err_d;

  logic             code_legal;
  logic [2:0]       code_idx;
  logic             is_succ;
  logic             is_hold;

  always_comb begin
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case (jc_in)
      4'b0000: code_idx = 3'd0;
      4'b1000: code_idx = 3'd1;
      4'b1100: code_idx = 3'd2;
      4'b1110: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b0111: code_idx = 3'd5;
      4'b0011: code_idx = 3'd6;
      4'b0001: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  // 3-bit add wraps 7 -> 0, which is exactly the Johnson successor.
  assign is_succ = (code_idx == (prev_q + 3'd1));
  assign is_hold = (code_idx == prev_q);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    phase_d   = phase_q;
    rev_d     = rev_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    skip_d    = 1'b0;

    if (valid) begin
      if (!code_legal) begin
        illegal_d = 1'b1;
        state_d   = ST_UNLOCKED;
      end else begin
        unique case (state_q)
          ST_UNLOCKED: begin
            prev_d  = code_idx;
            run_d   = 3'd0;
            state_d = ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (is_succ) begin
              prev_d = code_idx;
              run_d  = run_q + 3'd1;
              if ((run_q + 3'd1) == LOCK_RUN) begin
                state_d = ST_LOCKED;
              end
            end else if (!is_hold) begin
              prev_d = code_idx;
              run_d  = 3'd0;
            end
          end
          ST_LOCKED: begin
            if (is_succ || is_hold) begin
              prev_d = code_idx;
              if (is_succ && (code_idx == 3'd0)) begin
                wrap_d = 1'b1;
                rev_d  = rev_q + REV_ONE;
              end
            end else begin
              skip_d  = 1'b1;
              prev_d  = code_idx;
              run_d   = 3'd0;
              state_d = ST_ACQUIRE;
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end

    // Phase tracks prev only while (or on becoming) locked; otherwise it keeps its last value.
    if (state_d == ST_LOCKED) begin
      phase_d = prev_d;
    end
    phase_valid_d = (state_d == ST_LOCKED);
    onehot_d      = (state_d == ST_LOCKED) ? (8'd1 << prev_d) : 8'd0;

    if (illegal_d || skip_d) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_UNLOCKED;
      prev_q        <= 3'd0;
      run_q         <= 3'd0;
      phase_q       <= 3'd0;
      onehot_q      <= 8'd0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      rev_q         <= '0;
      illegal_q     <= 1'b0;
      skip_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      phase_q       <= phase_d;
      onehot_q      <= onehot_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
      rev_q         <= rev_d;
      illegal_q     <= illegal_d;
      skip_q        <= skip_d;
      err_q         <= err_d;
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = onehot_q;
  assign phase_valid  = phase_valid_q;
  assign wrap         = wrap_q;
  assign rev_count    = rev_q;
  assign illegal      = illegal_q;
  assign skip         = skip_q;
  assign err_sticky   = err_q;

`ifdef JPD_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A clear that coincides with a new error leaves that one error counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (illegal_d || skip_d) begin
      if (clr_err) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (clr_err) begin
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: spec-level reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_johnson_phase_decoder;

  localparam int REV_W    = 2;
  localparam int LOCK_CNT = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             valid;
  logic [3:0]       jc_in;
  logic             clr_err;
  logic [2:0]       phase;
  logic [7:0]       phase_onehot;
  logic             phase_valid;
  logic             wrap;
  logic [REV_W-1:0] rev_count;
  logic             illegal;
  logic             skip;
  logic             err_sticky;
`ifdef JPD_ERR_COUNT_EN
  logic [7:0]       err_count;
`endif

  johnson_phase_decoder #(.REV_W(REV_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid        (valid),
    .jc_in        (jc_in),
    .clr_err      (clr_err),
    .phase        (phase),
    .phase_onehot (phase_onehot),
    .phase_valid  (phase_valid),
    .wrap         (wrap),
    .rev_count    (rev_count),
    .illegal      (illegal),
    .skip         (skip),
    .err_sticky   (err_sticky)
`ifdef JPD_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [3:0] jc_tab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};

  // reference model: phase position, lock status and progress toward lock
  bit m_locked, m_acquiring;
  int m_prev, m_run, m_phase, m_rev, m_ecnt;
  bit m_wrap, m_ill, m_skip, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int decode(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (jc_tab[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_acquiring = 0; m_prev = 0; m_run = 0; m_phase = 0;
    m_rev = 0; m_ecnt = 0; m_wrap = 0; m_ill = 0; m_skip = 0; m_err = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c, input logic clr);
    int p;
    int nxt;
    m_wrap = 0; m_ill = 0; m_skip = 0;
    if (v) begin
      p   = decode(c);
      nxt = (m_prev + 1) % 8;
      if (p < 0) begin
        m_ill = 1; m_locked = 0; m_acquiring = 0;
      end else if (m_locked) begin
        if (p == nxt || p == m_prev) begin
          if (p == nxt && p == 0) begin
            m_wrap = 1;
            m_rev  = (m_rev + 1) % (1 << REV_W);
          end
          m_prev = p; m_phase = p;
        end else begin
          m_skip = 1; m_prev = p; m_run = 0; m_locked = 0; m_acquiring = 1;
        end
      end else if (m_acquiring) begin
        if (p == nxt) begin
          m_prev = p; m_run++;
          if (m_run == LOCK_CNT) begin
            m_acquiring = 0; m_locked = 1; m_phase = p;
          end
        end else if (p != m_prev) begin
          m_prev = p; m_run = 0;
        end
      end else begin
        m_prev = p; m_run = 0; m_acquiring = 1;
      end
    end
    if (m_ill || m_skip) begin
      m_err  = 1;
      m_ecnt = clr ? 1 : ((m_ecnt < 255) ? m_ecnt + 1 : 255);
    end else if (clr) begin
      m_err = 0; m_ecnt = 0;
    end
  endtask

  // scoreboard compare: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase", 32'(phase), 32'(m_phase));
      chk("phase_onehot", 32'(phase_onehot), m_locked ? (32'd1 << m_phase) : 32'd0);
      chk("phase_valid", 32'(phase_valid), 32'(m_locked));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("rev_count", 32'(rev_count), 32'(m_rev));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("skip", 32'(skip), 32'(m_skip));
      chk("err_sticky", 32'(err_sticky), 32'(m_err));
`ifdef JPD_ERR_COUNT_EN
      chk("err_count", 32'(err_count), 32'(m_ecnt));
`endif
    end
  end

  // driver tasks
  task automatic cyc(input logic v, input logic [3:0] c, input logic clr);
    valid = v; jc_in = c; clr_err = clr;
    @(posedge clk);
    model_step(v, c, clr);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; valid = 1'b1; jc_in = 4'b1000; clr_err = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset_n = 1'b1; valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_onehot"}, 32'(phase_onehot), 32'd0);
    chk({tag, "_pv"}, 32'(phase_valid), 32'd0);
    chk({tag, "_rev"}, 32'(rev_count), 32'd0);
    chk({tag, "_flags"}, {29'd0, wrap, illegal, skip}, 32'd0);
    chk({tag, "_err"}, 32'(err_sticky), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; jc_in = 4'b0000; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_en = 1'b1;
    chk_all_zero("reset");

    // clean lock: 20 samples of the legal sequence from 0000
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, jc_tab[k % 8], 1'b0);
      if (k == 1) chk("lock_not_yet", 32'(phase_valid), 32'd0);
      if (k == 2) begin
        chk("lock_edge3", 32'(phase_valid), 32'd1);
        chk("lock_phase2", 32'(phase), 32'd2);
      end
    end
    chk("clean_rev", 32'(rev_count), 32'd2);
    chk("clean_phase", 32'(phase), 32'd3);
    chk("clean_onehot", 32'(phase_onehot), 32'h08);
    chk("clean_err", 32'(err_sticky), 32'd0);

    // hold, then freeze with valid low
    repeat (5) cyc(1'b1, 4'b1110, 1'b0);
    chk("hold_phase", 32'(phase), 32'd3);
    chk("hold_onehot", 32'(phase_onehot), 32'h08);
    repeat (3) cyc(1'b0, 4'b1010, 1'b0);
    chk("freeze_pv", 32'(phase_valid), 32'd1);
    chk("freeze_illegal", 32'(illegal), 32'd0);

    // illegal code while locked, then re-lock
    cyc(1'b1, 4'b1010, 1'b0);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_pv", 32'(phase_valid), 32'd0);
    chk("ill_onehot", 32'(phase_onehot), 32'd0);
    chk("ill_err", 32'(err_sticky), 32'd1);
    chk("ill_phase_hold", 32'(phase), 32'd3);
    cyc(1'b1, jc_tab[4], 1'b0);
    chk("ill_one_cycle", 32'(illegal), 32'd0);
    cyc(1'b1, jc_tab[5], 1'b0);
    cyc(1'b1, jc_tab[6], 1'b0);
    chk("relock_pv", 32'(phase_valid), 32'd1);
    chk("relock_phase", 32'(phase), 32'd6);

    // skip 2 -> 5 while locked
    cyc(1'b1, jc_tab[7], 1'b0);
    cyc(1'b1, jc_tab[0], 1'b0);
    chk("wrap_pulse", 32'(wrap), 32'd1);
    chk("wrap_rev", 32'(rev_count), 32'd3);
    cyc(1'b1, jc_tab[1], 1'b0);
    cyc(1'b1, jc_tab[2], 1'b0);
    cyc(1'b1, 4'b0111, 1'b0);
    chk("skip_pulse", 32'(skip), 32'd1);
    chk("skip_pv", 32'(phase_valid), 32'd0);
    cyc(1'b1, 4'b0011, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0);
    chk("skip_relock_pv", 32'(phase_valid), 32'd1);
    chk("skip_relock_phase", 32'(phase), 32'd7);

    // back-to-back illegal codes, then clear race
    cyc(1'b1, 4'b0101, 1'b0);
    cyc(1'b1, 4'b1001, 1'b0);
    chk("ill_back2back", 32'(illegal), 32'd1);
    cyc(1'b1, 4'b1010, 1'b1);
    chk("race_err", 32'(err_sticky), 32'd1);
`ifdef JPD_ERR_COUNT_EN
    chk("race_cnt", 32'(err_count), 32'd1);
`endif
    cyc(1'b1, 4'b0000, 1'b1);
    chk("clr_err", 32'(err_sticky), 32'd0);
`ifdef JPD_ERR_COUNT_EN
    chk("clr_cnt", 32'(err_count), 32'd0);
`endif

    // five locked revolutions with a 2-bit counter, then mid-revolution reset
    do_reset();
    chk_all_zero("reset2");
    for (int k = 0; k < 44; k++) cyc(1'b1, jc_tab[k % 8], 1'b0);
    chk("rev_mod", 32'(rev_count), 32'd1);
    chk("rev_phase", 32'(phase), 32'd3);
    cyc(1'b1, jc_tab[4], 1'b0);
    do_reset();
    chk_all_zero("reset_mid");

    // re-lock after reset needs LOCK_CNT successor steps
    cyc(1'b1, jc_tab[4], 1'b0);
    cyc(1'b1, jc_tab[5], 1'b0);
    chk("post_reset_unlocked", 32'(phase_valid), 32'd0);
    cyc(1'b1, jc_tab[6], 1'b0);
    chk("post_reset_lock", 32'(phase_valid), 32'd1);
    chk("post_reset_phase", 32'(phase), 32'd6);
    cyc(1'b0, 4'b0000, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
